comparador_serial: RTL and testbench
====================================

# comparador_serial

Parametrised, sequential multi-bit magnitude comparator for the comparator family of the arithmetic problem set. It replaces fixed-width combinational equality checks with a WIDTH-bit compare. The operands are processed CHUNK bits per cycle, MSB first, with early termination on the first differing chunk. It reports eq/gt/lt through a start/busy/done handshake and holds the result until the next compare completes.

## Interface
- WIDTH, 8: operand width in bits; must be a multiple of CHUNK, ≥ 2.
- CHUNK, 2: bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK: number of chunks.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A (unsigned); sampled with accepted start.
- b  input  WIDTH  operand B (unsigned); sampled with accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid and updated.
- eq  output  1  a == b for the last completed compare.
- gt  output  1  a > b for the last completed compare.
- lt  output  1  a < b for the last completed compare.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All outputs are 0 at reset: busy, done, eq, gt, lt.
- IDLE: on start=1, latch a and b into internal registers, clear the chunk index to 0 (MSB chunk), and go to RUN. Otherwise stay in IDLE.
- RUN: busy=1. Compare chunk idx, i.e. bits [WIDTH-1-idx·CHUNK -: CHUNK], of the latched A and B.
  - Chunk A > chunk B: load gt=1, eq=0, lt=0, then go to DONE.
  - Chunk A < chunk B: load lt=1, eq=0, gt=0, then go to DONE.
  - Chunks equal and idx == NCHUNK-1: load eq=1, gt=0, lt=0, then go to DONE.
  - Chunks equal otherwise: idx+1, stay in RUN.
- DONE: done=1 and busy=0.
  - start=1 is accepted (back-to-back): relatch operands, idx=0, go to RUN.
  - Otherwise go to IDLE.
- start while in RUN is ignored. Operand changes on a/b while in RUN have no effect because the latched copies are used.
- eq/gt/lt are registered and hold their value until the next DONE. Exactly one of them is high after the first completed compare. They do not change at start.
- Unsigned arithmetic only. The chunk index is max(1, $clog2(NCHUNK)) bits wide and never wraps past NCHUNK-1.

## Timing
- Start accepted at edge 0. The RUN cycle for chunk k is cycle k+1. done is high in the cycle after the deciding RUN cycle.
- Latency from the start edge to done is k+2 cycles, where k is the 0-based index of the first differing chunk, or NCHUNK-1 if the operands are equal.
  - Minimum latency: 2 cycles.
  - Maximum latency: NCHUNK+1 cycles.
- Back-to-back throughput: one compare every k+2 cycles, because the DONE cycle overlaps with the next accept.
- eq/gt/lt change in the same cycle that done rises.
- Reset mid-RUN or mid-DONE: the block is in IDLE immediately and all outputs are 0. An in-flight compare is discarded and produces no done.
- With CHUNK == WIDTH (NCHUNK=1): every compare takes 2 cycles.

## Structure
- Shared header comparador_defs.vh holds the state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10. The encoding 2'b11 is illegal and recovers to IDLE.
- Sub-module cmp_chunk (combinational, parameter CHUNK): inputs x, y; outputs eq_c, gt_c. lt is derived as ~eq_c & ~gt_c.
- The top level contains the FSM, operand latches, chunk index, chunk mux and result registers.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 unless noted.
- a=8'hA5, b=8'hA5, start pulse: busy for 4 cycles, then done in cycle 5 with eq=1, gt=0, lt=0.
- a=8'h80, b=8'h7F: decided at chunk 0, done in cycle 2, gt=1. a=8'h12, b=8'h13: decided at chunk 3, done in cycle 5, lt=1.
- Start and change a/b during RUN: no restart, and the result matches the originally latched operands.
- Start held high across DONE: the second compare starts with no IDLE cycle between, and both done pulses carry the correct results.
- rst_n low for one cycle during RUN: all outputs 0 asynchronously, state IDLE, and no done follows.
- Parameter sweep WIDTH=8 with CHUNK=1/4/8, 500 random a/b pairs each: result matches $unsigned compare, and latency equals first-differing-chunk index + 2.

Source files
------------

// File: rtl/comparador_serial_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the chunk-index width helper.
package comparador_serial_pkg;

  // 2'b11 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/comparador_serial_cmp_chunk.sv
// Combinational compare of one CHUNK-bit slice; lt is implied by ~eq_c & ~gt_c.
module cmp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq_c,
  output logic             gt_c
);

  assign eq_c = (x == y);
  assign gt_c = (x > y);

endmodule

// File: rtl/comparador_serial.sv
// Sequential WIDTH-bit unsigned comparator, CHUNK bits per cycle MSB first,
// stopping at the first differing chunk; start/busy/done handshake.
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = int'(idx_width(NCHUNK));

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic [WIDTH-1:0] w_sha;
  logic [WIDTH-1:0] w_shb;
  logic [CHUNK-1:0] w_xa;
  logic [CHUNK-1:0] w_xb;
  logic             w_eq_c;
  logic             w_gt_c;
  logic             w_last;
  logic             w_accept;
  logic             w_decide;

  // Chunk mux: shift the selected chunk up to the MSB end, then slice it.
  assign w_sha = r_a << (CHUNK * int'(r_idx));
  assign w_shb = r_b << (CHUNK * int'(r_idx));
  assign w_xa  = w_sha[WIDTH-1 -: CHUNK];
  assign w_xb  = w_shb[WIDTH-1 -: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
    .x    (w_xa),
    .y    (w_xb),
    .eq_c (w_eq_c),
    .gt_c (w_gt_c)
  );

  assign w_last   = (r_idx == IW'(NCHUNK - 1));
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_decide = (r_state == RUN) && (!w_eq_c || w_last);

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (!w_eq_c || w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_idx <= '0;
      end else if ((r_state == RUN) && w_eq_c && !w_last) begin
        r_idx <= r_idx + IW'(1);
      end
      if (w_decide) begin
        r_eq <= w_eq_c;
        r_gt <= w_gt_c;
        r_lt <= ~w_eq_c & ~w_gt_c;
      end
    end
  end

  assign eq = r_eq;
  assign gt = r_gt;
  assign lt = r_lt;

endmodule

// File: tb/tb_comparador_serial.sv
// Bench for comparador_serial: scoreboarded vector table on WIDTH=8/CHUNK=2,
// handshake corner cases, and random sweeps on CHUNK=1/4/8 instances.
module tb_comparador_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, eq, gt, lt;

  always #5 clk = ~clk;

  comparador_serial #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  logic       sw_start [3];
  logic [7:0] sw_a     [3];
  logic [7:0] sw_b     [3];
  logic       sw_busy  [3];
  logic       sw_done  [3];
  logic       sw_eq    [3];
  logic       sw_gt    [3];
  logic       sw_lt    [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_sw
      comparador_serial #(.WIDTH(8), .CHUNK(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_sw (
        .clk(clk), .rst_n(rst_n), .start(sw_start[g]), .a(sw_a[g]), .b(sw_b[g]),
        .busy(sw_busy[g]), .done(sw_done[g]), .eq(sw_eq[g]), .gt(sw_gt[g]), .lt(sw_lt[g])
      );
    end
  endgenerate

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] res;   // {eq, gt, lt}
    int         lat;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         t0;
    int         lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending start.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 with no compare pending, required done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result_eqgtlt", int'({eq, gt, lt}), int'(e.res));
        check("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic push_exp(input logic [2:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.t0  = cyc;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] res, input int lat);
    @(posedge clk);
    #1;
    a     = va;
    b     = vb;
    start = 1'b1;
    push_exp(res, lat);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d compares pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y, input int c);
    int nc;
    int k;
    int xi, yi;
    nc = 8 / c;
    k  = nc - 1;
    for (int i = nc - 1; i >= 0; i--) begin
      xi = (int'(x) >> (8 - (i + 1) * c)) & ((1 << c) - 1);
      yi = (int'(y) >> (8 - (i + 1) * c)) & ((1 << c) - 1);
      if (xi != yi) k = i;
    end
    return k + 2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    logic [7:0] x, y;
    logic [2:0] r;
    bit         seen;
    int         t0, c;

    tbl[0] = '{8'hA5, 8'hA5, 3'b100, 5};
    tbl[1] = '{8'h80, 8'h7F, 3'b010, 2};
    tbl[2] = '{8'h12, 8'h13, 3'b001, 5};
    tbl[3] = '{8'h00, 8'h00, 3'b100, 5};
    tbl[4] = '{8'hFF, 8'h00, 3'b010, 2};
    tbl[5] = '{8'h00, 8'hFF, 3'b001, 2};
    tbl[6] = '{8'h3C, 8'h34, 3'b010, 4};
    tbl[7] = '{8'h40, 8'h50, 3'b001, 3};
    tbl[8] = '{8'hFF, 8'hFF, 3'b100, 5};
    tbl[9] = '{8'hFE, 8'hFF, 3'b001, 5};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    for (int i = 0; i < 3; i++) begin
      sw_start[i] = 1'b0;
      sw_a[i]     = '0;
      sw_b[i]     = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_eqgtlt", int'({eq, gt, lt}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].va, tbl[i].vb, tbl[i].res, tbl[i].lat);
      wait_drain();
    end

    // Operand changes and start during RUN must be ignored; result holds.
    issue(8'h3C, 8'h34, 3'b010, 4);
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    check("busy_in_run", int'(busy), 1);
    check("held_result", int'({eq, gt, lt}), int'(3'b001));
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();

    // Back-to-back: start held through DONE, second compare follows directly.
    @(posedge clk);
    #1;
    a     = 8'h80;
    b     = 8'h7F;
    start = 1'b1;
    push_exp(3'b010, 2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done_seen", int'(seen), 1);
    a = 8'h12;
    b = 8'h13;
    push_exp(3'b001, 5);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_no_idle_gap", int'(busy), 1);
    wait_drain();

    // Reset pulse mid-RUN: asynchronous clear, in-flight compare discarded.
    @(posedge clk);
    #1;
    a     = 8'h12;
    b     = 8'h13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_done", int'(done), 0);
    check("midrun_rst_eqgtlt", int'({eq, gt, lt}), 0);
    #9 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", int'(busy), 0);
    issue(8'h00, 8'h00, 3'b100, 5);
    wait_drain();

    // Random sweeps on the CHUNK=1/4/8 instances.
    for (int gi = 0; gi < 3; gi++) begin
      c = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
      for (int n = 0; n < 500; n++) begin
        x = 8'($urandom);
        case ($urandom_range(3))
          0:       y = x;
          1:       y = x ^ 8'(1 << $urandom_range(7));
          default: y = 8'($urandom);
        endcase
        r = (x == y) ? 3'b100 : ((x > y) ? 3'b010 : 3'b001);
        @(posedge clk);
        #1;
        sw_a[gi]     = x;
        sw_b[gi]     = y;
        sw_start[gi] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 sw_start[gi] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (sw_done[gi]) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          n_vec++;
          n_bad++;
          $display("FAIL sweep_timeout chunk=%0d: got no done for a=%h b=%h, required done", c, x, y);
        end else begin
          check($sformatf("sweep_result_c%0d", c), int'({sw_eq[gi], sw_gt[gi], sw_lt[gi]}), int'(r));
          check($sformatf("sweep_latency_c%0d", c), cyc - t0, exp_lat(x, y, c));
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
